// File: rtl/pda_pkg.sv
// Shared types and constants for the a^i b^j c^k string generator.
package pda_pkg;

  // Default width of each run-length count.
  localparam int unsigned CntWDefault = 16;

  // Width of every emitted character.
  localparam int unsigned TermW = 8;

  // Generator phases: idle, the three character runs, optional terminator.
  typedef enum logic [2:0] {
    StIdle,
    StRunA,
    StRunB,
    StRunC,
    StTerm
  } pda_state_e;

endpackage

// File: rtl/pda_run_ctr.sv
// Loadable down-counter with a last-flag; one instance is shared by all three runs.
module pda_run_ctr
  import pda_pkg::*;
#(
  parameter int unsigned CNT_W = CntWDefault
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] count_o,
  output logic             last_o
);

  logic [CNT_W-1:0] count_q;

  // Load has priority; decrement saturates at zero so an idle counter never wraps.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  // The character currently on the output is the final one of its run.
  always_comb begin
    last_o = (count_q == CNT_W'(1));
  end

  assign count_o = count_q;

endmodule

// File: rtl/pda_gen.sv
// Emits first_term^i second_term^j third_term^k over a valid/ready stream.
// Define PDA_GEN_TERMINATOR_EN to append sep_term as the final character.
module pda_gen
  import pda_pkg::*;
#(
  parameter int unsigned CNT_W = CntWDefault
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] count_a,
  input  logic [CNT_W-1:0] count_b,
  input  logic [CNT_W-1:0] count_c,
  input  logic [TermW-1:0] first_term,
  input  logic [TermW-1:0] second_term,
  input  logic [TermW-1:0] third_term,
  input  logic [TermW-1:0] sep_term,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TermW-1:0] out_char,
  output logic             out_last,
  output logic             exp_match,
  output logic             cmd_err
);

`ifdef PDA_GEN_TERMINATOR_EN
  localparam bit TermEn = 1'b1;
`else
  localparam bit TermEn = 1'b0;
`endif

  pda_state_e state_q, state_d;

  logic             out_valid_q, out_valid_d;
  logic [TermW-1:0] out_char_q, out_char_d;
  logic             out_last_q, out_last_d;
  logic             exp_match_q, exp_match_d;
  logic             cmd_err_q, cmd_err_d;

  // Captured command fields still needed after acceptance; the first run's
  // character lives directly in out_char_q.
  logic [CNT_W-1:0] cnt_b_q, cnt_b_d;
  logic [CNT_W-1:0] cnt_c_q, cnt_c_d;
  logic [TermW-1:0] term_b_q, term_b_d;
  logic [TermW-1:0] term_c_q, term_c_d;
  logic [TermW-1:0] sep_q, sep_d;

  logic             ctr_load;
  logic [CNT_W-1:0] ctr_load_val;
  logic             ctr_dec;
  logic [CNT_W-1:0] ctr_count;
  logic             ctr_last;

  logic out_hs;
  logic cmd_bad;

  assign cmd_ready = (state_q == StIdle);
  assign out_hs    = out_valid_q && out_ready;
  assign cmd_bad   = (count_a == '0) || (count_b == '0) || (count_c == '0);

  pda_run_ctr #(
    .CNT_W (CNT_W)
  ) u_run_ctr (
    .clock      (clock),
    .reset      (reset),
    .load_i     (ctr_load),
    .load_val_i (ctr_load_val),
    .dec_i      (ctr_dec),
    .count_o    (ctr_count),
    .last_o     (ctr_last)
  );

  // Next-state and next-output decode; the output registers always hold the
  // character under offer, so run boundaries swap it in on the handshake edge.
  always_comb begin
    state_d      = state_q;
    out_valid_d  = out_valid_q;
    out_char_d   = out_char_q;
    out_last_d   = out_last_q;
    exp_match_d  = exp_match_q;
    cmd_err_d    = 1'b0;
    cnt_b_d      = cnt_b_q;
    cnt_c_d      = cnt_c_q;
    term_b_d     = term_b_q;
    term_c_d     = term_c_q;
    sep_d        = sep_q;
    ctr_load     = 1'b0;
    ctr_load_val = '0;
    ctr_dec      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          if (cmd_bad) begin
            cmd_err_d = 1'b1;
          end else begin
            state_d      = StRunA;
            ctr_load     = 1'b1;
            ctr_load_val = count_a;
            cnt_b_d      = count_b;
            cnt_c_d      = count_c;
            term_b_d     = second_term;
            term_c_d     = third_term;
            sep_d        = sep_term;
            out_valid_d  = 1'b1;
            out_char_d   = first_term;
            out_last_d   = 1'b0;
            exp_match_d  = (count_a == count_b) || (count_a == count_c);
          end
        end
      end

      StRunA: begin
        if (out_hs) begin
          if (ctr_last) begin
            state_d      = StRunB;
            ctr_load     = 1'b1;
            ctr_load_val = cnt_b_q;
            out_char_d   = term_b_q;
          end else begin
            ctr_dec = 1'b1;
          end
        end
      end

      StRunB: begin
        if (out_hs) begin
          if (ctr_last) begin
            state_d      = StRunC;
            ctr_load     = 1'b1;
            ctr_load_val = cnt_c_q;
            out_char_d   = term_c_q;
            // Without a terminator a single-character c run is the string end.
            out_last_d   = !TermEn && (cnt_c_q == CNT_W'(1));
          end else begin
            ctr_dec = 1'b1;
          end
        end
      end

      StRunC: begin
        if (out_hs) begin
          if (ctr_last) begin
            if (TermEn) begin
              state_d    = StTerm;
              out_char_d = sep_q;
              out_last_d = 1'b1;
            end else begin
              state_d     = StIdle;
              out_valid_d = 1'b0;
              out_last_d  = 1'b0;
            end
          end else begin
            ctr_dec    = 1'b1;
            // Flag the next character if it will be the final c.
            out_last_d = !TermEn && (ctr_count == CNT_W'(2));
          end
        end
      end

      StTerm: begin
        if (out_hs) begin
          state_d     = StIdle;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end
      end

      default: begin
        state_d     = StIdle;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset abandons any string in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      out_char_q  <= '0;
      out_last_q  <= 1'b0;
      exp_match_q <= 1'b0;
      cmd_err_q   <= 1'b0;
      cnt_b_q     <= '0;
      cnt_c_q     <= '0;
      term_b_q    <= '0;
      term_c_q    <= '0;
      sep_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_char_q  <= out_char_d;
      out_last_q  <= out_last_d;
      exp_match_q <= exp_match_d;
      cmd_err_q   <= cmd_err_d;
      cnt_b_q     <= cnt_b_d;
      cnt_c_q     <= cnt_c_d;
      term_b_q    <= term_b_d;
      term_c_q    <= term_c_d;
      sep_q       <= sep_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_char  = out_char_q;
  assign out_last  = out_last_q;
  assign exp_match = exp_match_q;
  assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_pda_gen.sv
// Self-checking bench for pda_gen: a queue-based reference model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_pda_gen;

  localparam int unsigned CW = 16;
`ifdef PDA_GEN_TERMINATOR_EN
  localparam bit TERM_EN = 1'b1;
`else
  localparam bit TERM_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [CW-1:0] count_a, count_b, count_c;
  logic [7:0]    first_term, second_term, third_term, sep_term;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_char;
  logic          out_last;
  logic          exp_match;
  logic          cmd_err;

  always #5 clock = ~clock;

  pda_gen #(
    .CNT_W (CW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .count_a     (count_a),
    .count_b     (count_b),
    .count_c     (count_c),
    .first_term  (first_term),
    .second_term (second_term),
    .third_term  (third_term),
    .sep_term    (sep_term),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_char    (out_char),
    .out_last    (out_last),
    .exp_match   (exp_match),
    .cmd_err     (cmd_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
    end
  endtask

  // Reference model: the remaining characters of the current string, each with its last flag.
  typedef struct packed {
    logic       last;
    logic [7:0] ch;
  } ent_t;

  ent_t exp_q[$];
  bit   em_m  = 1'b0;
  bit   err_m = 1'b0;

  function automatic void push_string(input int i, input int j, input int k,
                                      input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c, input logic [7:0] s);
    ent_t e;
    for (int n = 0; n < i; n++) begin e.last = 1'b0; e.ch = a; exp_q.push_back(e); end
    for (int n = 0; n < j; n++) begin e.last = 1'b0; e.ch = b; exp_q.push_back(e); end
    for (int n = 0; n < k; n++) begin
      e.last = !TERM_EN && (n == k - 1);
      e.ch   = c;
      exp_q.push_back(e);
    end
    if (TERM_EN) begin e.last = 1'b1; e.ch = s; exp_q.push_back(e); end
  endfunction

  // Observation state shared with the directed scenarios.
  string      rx = "";
  int         rx_n = 0;
  int         last_cnt = 0;
  int         last_hs_cyc = 0;
  int         accept_cyc = 0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_char;
  logic       prev_last;

  // Compare DUT against the model mid-cycle, then advance the model to the next edge.
  always @(negedge clock) begin
    if (!reset) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_out_char", out_char, 0);
      chk("rst_exp_match", exp_match, 0);
      chk("rst_cmd_err", cmd_err, 0);
      exp_q.delete();
      em_m       = 1'b0;
      err_m      = 1'b0;
      prev_stall = 1'b0;
    end else begin
      chk("cmd_ready", cmd_ready, exp_q.size() == 0);
      chk("out_valid", out_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        chk("out_char", out_char, exp_q[0].ch);
        chk("out_last", out_last, exp_q[0].last);
      end
      chk("exp_match", exp_match, em_m);
      chk("cmd_err", cmd_err, err_m);
      if (prev_stall) chk("stall_hold", {out_valid, out_last, out_char}, {1'b1, prev_last, prev_char});

      if (out_valid && out_ready) begin
        if (rx.len() < 64) rx = $sformatf("%s%c", rx, out_char);
        rx_n++;
        if (out_last) begin
          last_cnt++;
          last_hs_cyc = cyc;
        end
      end
      if (cmd_valid && cmd_ready) accept_cyc = cyc;
      prev_stall = out_valid && !out_ready;
      prev_char  = out_char;
      prev_last  = out_last;

      err_m = 1'b0;
      if (exp_q.size() == 0) begin
        if (cmd_valid) begin
          if (count_a == 0 || count_b == 0 || count_c == 0) begin
            err_m = 1'b1;
          end else begin
            push_string(int'(count_a), int'(count_b), int'(count_c),
                        first_term, second_term, third_term, sep_term);
            em_m = (count_a == count_b) || (count_a == count_c);
          end
        end
      end else if (out_ready) begin
        void'(exp_q.pop_front());
      end
    end
  end

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic send_cmd(input int i, input int j, input int k, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] c, input logic [7:0] s);
    int n = 0;
    while (!cmd_ready && n < 1000) begin @(posedge clock); #1; n++; end
    chk("send_idle_wait", cmd_ready, 1);
    count_a     = CW'(i);
    count_b     = CW'(j);
    count_c     = CW'(k);
    first_term  = a;
    second_term = b;
    third_term  = c;
    sep_term    = s;
    cmd_valid   = 1'b1;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input bit rand_rdy, input int limit);
    int n = 0;
    while (!cmd_ready && n < limit) begin
      @(posedge clock); #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
      n++;
    end
    chk("done_wait", cmd_ready, 1);
  endtask

  function automatic string with_sep(input string s);
    return TERM_EN ? {s, "#"} : s;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation still running at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int err_cnt, ov_cnt, nr_cnt, idx;
    bit [3:0] pat;

    reset = 1'b0; cmd_valid = 1'b0; out_ready = 1'b0;
    count_a = '0; count_b = '0; count_c = '0;
    first_term = '0; second_term = '0; third_term = '0; sep_term = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    chk("ready_after_reset", cmd_ready, 1);

    // i=2 j=2 k=1: equal counts set exp_match.
    out_ready = 1'b1; rx = ""; last_cnt = 0;
    send_cmd(2, 2, 1, "a", "b", "c", "#");
    wait_done(0, 100);
    chk_str("str_2_2_1", rx, with_sep("aabbc"));
    chk("em_2_2_1", exp_match, 1);
    chk("last_once_2_2_1", last_cnt, 1);

    // i=3 j=1 k=2: no equal counts.
    rx = ""; last_cnt = 0;
    send_cmd(3, 1, 2, "a", "b", "c", "#");
    wait_done(0, 100);
    chk_str("str_3_1_2", rx, with_sep("aaabcc"));
    chk("em_3_1_2", exp_match, 0);
    chk("last_once_3_1_2", last_cnt, 1);

    // Zero count is rejected: one-cycle error, no output, exp_match kept.
    err_cnt = 0; ov_cnt = 0; nr_cnt = 0;
    send_cmd(2, 0, 2, "x", "y", "z", "#");
    for (int n = 0; n < 4; n++) begin
      if (cmd_err) err_cnt++;
      if (out_valid) ov_cnt++;
      if (!cmd_ready) nr_cnt++;
      @(posedge clock); #1;
    end
    chk("rej_err_cycles", err_cnt, 1);
    chk("rej_out_valid", ov_cnt, 0);
    chk("rej_ready_low", nr_cnt, 0);
    chk("rej_em_kept", exp_match, 0);

    // Stalls with out_ready pattern 1,0,0,1.
    out_ready = 1'b0; rx = "";
    send_cmd(1, 1, 1, "a", "b", "c", "#");
    pat = 4'b1001; idx = 0;
    while (!cmd_ready && idx < 100) begin
      out_ready = pat[idx % 4];
      idx++;
      @(posedge clock); #1;
    end
    chk_str("str_stall", rx, with_sep("abc"));

    // Reset in the middle of the b run.
    out_ready = 1'b1; rx = "";
    send_cmd(4, 4, 4, "a", "b", "c", "#");
    repeat (5) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_char", out_char, 0);
    chk("midrst_exp_match", exp_match, 0);
    chk_str("midrst_partial", rx, "aaaab");
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    chk("midrst_ready", cmd_ready, 1);
    rx = "";
    send_cmd(1, 1, 1, "a", "b", "c", "#");
    wait_done(0, 100);
    chk_str("str_after_rst", rx, with_sep("abc"));

    // Back-to-back commands with cmd_valid held high.
    rx = "";
    count_a = 2; count_b = 1; count_c = 1;
    first_term = "a"; second_term = "b"; third_term = "c"; sep_term = "#";
    cmd_valid = 1'b1;
    @(posedge clock); #1;
    count_a = 1; count_b = 2; count_c = 1;
    idx = 0;
    while (idx < 100) begin
      @(posedge clock); #1;
      idx++;
      if (cmd_ready) begin
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        break;
      end
    end
    chk("b2b_accept_gap", accept_cyc - last_hs_cyc, 1);
    wait_done(0, 100);
    chk_str("str_b2b", rx, {with_sep("aabc"), with_sep("abbc")});

    // Randomized commands and backpressure; zero counts exercise rejection.
    for (int t = 0; t < 30; t++) begin
      send_cmd(int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
               int'($urandom_range(0, 5)), 8'($urandom), 8'($urandom),
               8'($urandom), 8'($urandom));
      wait_done(1, 500);
    end

    // Maximum count: exactly 2^CW-1 first characters, no wrap.
    out_ready = 1'b1; rx_n = 0;
    send_cmd(65535, 1, 1, "a", "b", "c", "#");
    wait_done(0, 70000);
    chk("max_count_chars", rx_n, 65535 + 2 + int'(TERM_EN));

    repeat (2) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pda_gen.md
PDA_GEN -- requirements
Module: pda_gen

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of each run count.
REQ-002 SHALL have port clock, input, 1: single rising-edge clock.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port cmd_valid, input, 1: command offered.
REQ-005 SHALL have port cmd_ready, output, 1: command accepted when both cmd_valid and cmd_ready are high.
REQ-006 SHALL have ports count_a, count_b and count_c, input, CNT_W each: run lengths i, j, k.
REQ-007 SHALL have ports first_term, second_term and third_term, input, 8 each: characters for the three runs.
REQ-008 SHALL have port sep_term, input, 8: terminator character.
REQ-009 SHALL have port out_valid, output, 1: out_char is valid.
REQ-010 SHALL have port out_ready, input, 1: sink accepts the character.
REQ-011 SHALL have port out_char, output, 8: emitted character.
REQ-012 SHALL have port out_last, output, 1: marks the final character of a string.
REQ-013 SHALL have port exp_match, output, 1: registered value of (i==j)|(i==k) for the current string.
REQ-014 SHALL have port cmd_err, output, 1: one-cycle pulse when a command is rejected.

Function
REQ-015 SHALL emit the string a^i b^j c^k (first_term repeated i times, then second_term j times, then third_term k times), one character per accepted output handshake.
REQ-016 SHALL implement states IDLE, RUN_A, RUN_B, RUN_C and TERM, with transitions IDLE->RUN_A->RUN_B->RUN_C->(TERM)->IDLE.
REQ-017 SHALL drive cmd_ready high only in IDLE.
REQ-018 SHALL, on command acceptance, capture all counts and terms.
REQ-019 SHALL compute exp_match from the captured counts and hold it stable until the next acceptance.
REQ-020 SHALL raise out_valid in the cycle after command acceptance (latency 1), with out_char=first_term.
REQ-021 SHALL hold out_char, out_last and out_valid stable while out_valid=1 and out_ready=0.
REQ-022 SHALL, with out_ready held high, emit one character per cycle with no bubbles, including at run boundaries.
REQ-023 SHALL use a per-run down-counter, loaded with the run length and decremented on each handshake; the run ends when the counter reaches 1 and a handshake occurs.
REQ-024 SHALL reject any command with count_a, count_b or count_c equal to 0: pulse cmd_err for one cycle, produce no output, remain in IDLE, leave exp_match unchanged.
REQ-025 SHALL handle count=2^CNT_W-1 without wrap-around: exactly that many characters are emitted.
REQ-026 SHALL return to IDLE in the cycle after the out_last handshake.
REQ-027 SHALL allow a new command to be accepted in IDLE in the cycle after that return.

Reset
REQ-028 SHALL, on reset assertion, immediately force the state to IDLE, out_valid=0, out_last=0, out_char=8'h00, exp_match=0, cmd_err=0 and all counters to 0.
REQ-029 SHALL drive cmd_ready=1 in the first cycle after reset release.
REQ-030 SHALL, on reset asserted mid-string, abandon the string; no further characters of it are emitted after reset release.

Configuration
REQ-031 SHALL, with PDA_GEN_TERMINATOR_EN defined, enter TERM after the last c and emit sep_term as the final character with out_last=1.
REQ-032 SHALL, without PDA_GEN_TERMINATOR_EN, omit TERM; the last third_term carries out_last=1 and sep_term is unused.

Structure
REQ-033 SHALL place the state enum, CNT_W default and term-character width constant in shared package pda_pkg.
REQ-034 SHALL instantiate sub-module pda_run_ctr (loadable down-counter with a last-flag) once, reused across the three runs.

Verification
REQ-035 SHALL verify: i=2,j=2,k=1, terms 'a','b','c','#', out_ready=1, TERMINATOR_EN -> out_char sequence "aabbc#", exp_match=1, out_last only on '#'.
REQ-036 SHALL verify: i=3,j=1,k=2 -> "aaabcc", exp_match=0; without TERMINATOR_EN, out_last is on the second 'c'.
REQ-037 SHALL verify: count_b=0 -> cmd_err is high for exactly 1 cycle, out_valid stays 0, cmd_ready stays 1.
REQ-038 SHALL verify: i=j=k=1 with out_ready toggling 1,0,0,1 -> each character is held stable while stalled, "abc" is delivered in order, with no duplicates.
REQ-039 SHALL verify: reset asserted during RUN_B of i=4,j=4,k=4 -> out_valid=0 immediately, cmd_ready=1 after release, next command i=1,j=1,k=1 emits "abc".
REQ-040 SHALL verify: back-to-back commands -> second command is accepted exactly 1 cycle after the first string's out_last handshake.
